// File: rtl/prll_bs_pkg.sv
// prll_bs_pkg: shared types and helpers for the parallel-bus round-robin sequencer.
package prll_bs_pkg;

    typedef enum logic [1:0] {IDLE, POP, DELIVER} state_e;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_ID = {ID_W{1'b1}};

    // Destination ID sits in the top ID_W bits of a bits-wide word (zero-extended to 64).
    function automatic logic [ID_W-1:0] id_of(input logic [63:0] word, input int bits);
        return ID_W'(word >> (bits - ID_W));
    endfunction

endpackage

// File: rtl/prll_bs_rr_pick.sv
// prll_bs_rr_pick: combinational round-robin search, first pending index after last_i.
module prll_bs_rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0] pndng_i,
    input  logic [2:0]   last_i,
    output logic [2:0]   winner_o,
    output logic         valid_o
);

    logic [3:0] idx;

    // Scan from farthest to nearest so the closest pending driver after last_i wins.
    always_comb begin
        winner_o = '0;
        idx      = '0;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, last_i} + 4'(k);
            idx = (idx >= 4'(N)) ? idx - 4'(N) : idx;
            if (pndng_i[idx[2:0]]) winner_o = idx[2:0];
        end
        valid_o = |pndng_i;
    end

endmodule

// File: rtl/prll_bs_rr_sqncr.sv
// prll_bs_rr_sqncr: round-robin bus sequencer, pops one driver word and pushes it to its destination(s).
// Optional stall timeout in DELIVER enabled by defining PRLL_BS_STALL_TIMEOUT_EN.
module prll_bs_rr_sqncr
    import prll_bs_pkg::*;
#(
    parameter int              bits      = 32,
    parameter int              drvrs     = 5,
    parameter logic [ID_W-1:0] broadcast = BCAST_ID,
    parameter int              TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [drvrs-1:0]       pndng,
    input  logic [drvrs*bits-1:0]  D_pop,
    input  logic [drvrs-1:0]       full,
    output logic [drvrs-1:0]       pop,
    output logic [drvrs-1:0]       push,
    output logic [drvrs*bits-1:0]  D_push,
    output logic [2:0]             gnt_id,
    output logic                   busy,
    output logic                   drop
);

    if (drvrs < 2 || drvrs > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("prll_bs_rr_sqncr: unsupported drvrs or TIMEOUT");
    end

    state_e           state_q, state_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic [2:0]       last_q, last_d;
    logic [bits-1:0]  hold_q, hold_d;
    logic [drvrs-1:0] mask_q, mask_d;
    logic             drop_q, drop_d;
    logic [2:0]       winner;
    logic             win_v;
    logic [ID_W-1:0]  id;
    logic [drvrs-1:0] self_m;
    logic             blocked;
    logic             expire;

    prll_bs_rr_pick #(.N(drvrs)) u_pick (
        .pndng_i  (pndng),
        .last_i   (last_q),
        .winner_o (winner),
        .valid_o  (win_v)
    );

    assign id      = id_of(64'(hold_q), bits);
    assign self_m  = drvrs'(1) << gnt_id_q;
    // Broadcast is atomic: any full target blocks the whole push.
    assign blocked = |(mask_q & full);

`ifdef PRLL_BS_STALL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    assign expire = cnt_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= (state_q == DELIVER && blocked) ? cnt_q + 1'b1 : '0;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        hold_d   = hold_q;
        mask_d   = mask_q;
        drop_d   = 1'b0;
        pop      = '0;
        push     = '0;
        case (state_q)
            IDLE: if (win_v) begin
                gnt_id_d = winner;
                hold_d   = bits'(D_pop >> (int'(winner) * bits));
                state_d  = POP;
            end
            POP: begin
                pop    = self_m;
                last_d = gnt_id_q;
                if (id == broadcast) begin
                    mask_d  = ~self_m;
                    state_d = DELIVER;
                end else if (int'(id) < drvrs && int'(id) != int'(gnt_id_q)) begin
                    mask_d  = drvrs'(1) << id;
                    state_d = DELIVER;
                end else begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DELIVER: if (!blocked) begin
                push    = mask_q;
                state_d = IDLE;
            end else if (expire) begin
                drop_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_id_q <= '0;
            last_q   <= 3'(drvrs - 1);
            hold_q   <= '0;
            mask_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            mask_q   <= mask_d;
            drop_q   <= drop_d;
        end
    end

    assign D_push = {drvrs{hold_q}};
    assign gnt_id = gnt_id_q;
    assign busy   = state_q != IDLE;
    assign drop   = drop_q;

endmodule

// File: tb/tb_prll_bs_rr_sqncr.sv
// tb_prll_bs_rr_sqncr: scenario tasks plus a pop/push scoreboard for prll_bs_rr_sqncr.
module tb_prll_bs_rr_sqncr;

    logic         clk = 0;
    logic         reset = 1;
    logic [4:0]   pndng = '0;
    logic [159:0] D_pop = '0;
    logic [4:0]   full = '0;
    logic [4:0]   pop, push;
    logic [159:0] D_push;
    logic [2:0]   gnt_id;
    logic         busy, drop;

    int tests = 0;
    int fails = 0;

    int          exp_pop[$];
    logic [4:0]  exp_mask[$];
    logic [31:0] exp_word[$];

    prll_bs_rr_sqncr dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
        .pop(pop), .push(push), .D_push(D_push), .gnt_id(gnt_id), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Scoreboard: every pop and push must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (pop !== 5'b0) begin
                tests++;
                if (exp_pop.size() == 0) begin
                    fails++;
                    $display("FAIL pop_unexpected got=%b", pop);
                end else begin
                    int g;
                    g = exp_pop.pop_front();
                    if (pop !== (5'b1 << g)) begin
                        fails++;
                        $display("FAIL pop_order got=%b exp=%b", pop, 5'b1 << g);
                    end
                end
            end
            if (push !== 5'b0) begin
                tests++;
                if (exp_mask.size() == 0) begin
                    fails++;
                    $display("FAIL push_unexpected got=%b data=%h", push, D_push[31:0]);
                end else begin
                    logic [4:0]  m;
                    logic [31:0] w;
                    m = exp_mask.pop_front();
                    w = exp_word.pop_front();
                    if (push !== m || D_push !== {5{w}}) begin
                        fails++;
                        $display("FAIL push_data got=%b/%h exp=%b/%h", push, D_push[31:0], m, w);
                    end
                end
            end
        end
    end

    task automatic set_lane(input int i, input logic [31:0] w);
        D_pop[i*32 +: 32] = w;
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (exp_pop.size() != 0 || exp_mask.size() != 0) begin
            fails++;
            $display("FAIL %s_drained pops_left=%0d pushes_left=%0d", name, exp_pop.size(), exp_mask.size());
        end
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({pop, push, gnt_id, busy, drop} !== '0 || D_push !== '0) begin
            fails++;
            $display("FAIL reset_values got pop=%b push=%b gnt=%0d busy=%b drop=%b", pop, push, gnt_id, busy, drop);
        end
        @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_basic();
        pndng = 5'b00100;
        set_lane(2, 32'h0100ABCD);
        exp_pop.push_back(2);
        exp_mask.push_back(5'b00010);
        exp_word.push_back(32'h0100ABCD);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || pop !== 5'b0) begin
            fails++;
            $display("FAIL basic_idle busy=%b pop=%b exp 0/00000", busy, pop);
        end
        @(posedge clk);
        #1 pndng = '0;
        @(negedge clk);
        tests++;
        if (pop !== 5'b00100 || busy !== 1'b1 || gnt_id !== 3'd2) begin
            fails++;
            $display("FAIL basic_pop pop=%b busy=%b gnt=%0d exp 00100/1/2", pop, busy, gnt_id);
        end
        @(negedge clk);
        tests++;
        if (push !== 5'b00010 || busy !== 1'b1 || D_push[31:0] !== 32'h0100ABCD) begin
            fails++;
            $display("FAIL basic_push push=%b busy=%b data=%h exp 00010/1/0100abcd", push, busy, D_push[31:0]);
        end
        @(negedge clk);
        tests++;
        if (push !== 5'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done push=%b busy=%b exp 00000/0", push, busy);
        end
        check_drained("basic");
    endtask

    task automatic test_round_robin();
        int n, last_c, prev;
        do_reset();
        for (int i = 0; i < 5; i++) set_lane(i, {8'((i + 1) % 5), 24'(i * 24'h111111)});
        for (int k = 0; k < 6; k++) begin
            exp_pop.push_back(k % 5);
            exp_mask.push_back(5'b1 << ((k % 5 + 1) % 5));
            exp_word.push_back({8'((k % 5 + 1) % 5), 24'((k % 5) * 24'h111111)});
        end
        pndng  = 5'b11111;
        n      = 0;
        last_c = -1;
        prev   = -1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (pop !== 5'b0) begin
                tests++;
                if (int'(gnt_id) == prev) begin
                    fails++;
                    $display("FAIL rr_repeat got=%0d prev=%0d", gnt_id, prev);
                end
                if (last_c >= 0) begin
                    tests++;
                    if (c - last_c != 3) begin
                        fails++;
                        $display("FAIL rr_spacing got=%0d exp=3", c - last_c);
                    end
                end
                prev   = int'(gnt_id);
                last_c = c;
                n++;
            end
        end
        tests++;
        if (n != 6) begin
            fails++;
            $display("FAIL rr_count got=%0d exp=6", n);
        end
        @(posedge clk);
        #1 pndng = '0;
        repeat (3) @(negedge clk);
        check_drained("rr");
    endtask

    task automatic test_broadcast();
        set_lane(1, 32'hFF000055);
        exp_pop.push_back(1);
        exp_mask.push_back(5'b11101);
        exp_word.push_back(32'hFF000055);
        pndng = 5'b00010;
        full  = 5'b01000;
        @(posedge clk);
        #1 pndng = '0;
        @(negedge clk);
        tests++;
        if (pop !== 5'b00010) begin
            fails++;
            $display("FAIL bcast_pop got=%b exp=00010", pop);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (push !== 5'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL bcast_stall cyc=%0d push=%b busy=%b exp 00000/1", i, push, busy);
            end
        end
        @(posedge clk);
        #1 full = '0;
        @(negedge clk);
        tests++;
        if (push !== 5'b11101) begin
            fails++;
            $display("FAIL bcast_push got=%b exp=11101", push);
        end
        @(negedge clk);
        tests++;
        if (push !== 5'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bcast_once push=%b busy=%b exp 00000/0", push, busy);
        end
        check_drained("bcast");
    endtask

    task automatic test_drop();
        logic [7:0] ids [3];
        ids = '{8'h07, 8'h00, 8'h05};
        for (int k = 0; k < 3; k++) begin
            set_lane(0, {ids[k], 24'h00C0DE});
            exp_pop.push_back(0);
            pndng = 5'b00001;
            @(posedge clk);
            #1 pndng = '0;
            @(negedge clk);
            tests++;
            if (pop !== 5'b00001 || drop !== 1'b0) begin
                fails++;
                $display("FAIL drop_pop id=%h pop=%b drop=%b exp 00001/0", ids[k], pop, drop);
            end
            @(negedge clk);
            tests++;
            if (drop !== 1'b1 || push !== 5'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL drop_pulse id=%h drop=%b push=%b busy=%b exp 1/00000/0", ids[k], drop, push, busy);
            end
            @(negedge clk);
            tests++;
            if (drop !== 1'b0) begin
                fails++;
                $display("FAIL drop_width id=%h drop=%b exp 0", ids[k], drop);
            end
        end
        check_drained("drop");
    endtask

    task automatic test_reset_mid();
        set_lane(3, 32'h02333333);
        exp_pop.push_back(3);
        full  = 5'b00100;
        pndng = 5'b01000;
        @(posedge clk);
        #1 pndng = '0;
        repeat (4) @(negedge clk);
        #2 reset = 1;
        #1;
        tests++;
        if ({pop, push, gnt_id, busy, drop} !== '0 || D_push !== '0) begin
            fails++;
            $display("FAIL reset_async pop=%b push=%b gnt=%0d busy=%b drop=%b", pop, push, gnt_id, busy, drop);
        end
        @(posedge clk);
        #1;
        set_lane(4, 32'h00444444);
        exp_pop.push_back(4);
        exp_mask.push_back(5'b00001);
        exp_word.push_back(32'h00444444);
        pndng = 5'b10000;
        reset = 0;
        @(posedge clk);
        #1 pndng = '0;
        @(negedge clk);
        tests++;
        if (pop !== 5'b10000 || push !== 5'b0) begin
            fails++;
            $display("FAIL reset_regrant pop=%b push=%b exp 10000/00000", pop, push);
        end
        repeat (3) @(negedge clk);
        full = '0;
        check_drained("reset_mid");
    endtask

    task automatic test_stall();
        set_lane(0, 32'h02ABCDEF);
        exp_pop.push_back(0);
        full  = 5'b00100;
        pndng = 5'b00001;
        @(posedge clk);
        #1 pndng = '0;
        @(negedge clk);
`ifdef PRLL_BS_STALL_TIMEOUT_EN
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            tests++;
            if (drop !== (i == 17) || busy !== (i <= 16) || push !== 5'b0) begin
                fails++;
                $display("FAIL stall_timeout cyc=%0d drop=%b busy=%b push=%b", i, drop, busy, push);
            end
        end
        @(posedge clk);
        #1 full = '0;
        repeat (2) @(negedge clk);
`else
        exp_mask.push_back(5'b00100);
        exp_word.push_back(32'h02ABCDEF);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            tests++;
            if (drop !== 1'b0 || busy !== 1'b1 || push !== 5'b0) begin
                fails++;
                $display("FAIL stall_wait cyc=%0d drop=%b busy=%b push=%b exp 0/1/00000", i, drop, busy, push);
            end
        end
        @(posedge clk);
        #1 full = '0;
        @(negedge clk);
        tests++;
        if (push !== 5'b00100) begin
            fails++;
            $display("FAIL stall_release got=%b exp=00100", push);
        end
        @(negedge clk);
`endif
        check_drained("stall");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_broadcast();
        test_drop();
        test_reset_mid();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prll_bs_rr_sqncr.md
Name: prll_bs_rr_sqncr

Overview:
- Round-robin bus sequencer for the parallel-bus fabric shared by `drvrs` driver FIFOs.
- Grants one pending driver at a time and pops one word from it.
- Decodes the destination ID from the top 8 bits of the word and pushes the word to the destination driver. A broadcast ID pushes to every driver except the source.
- Honours per-destination full backpressure.
- Sits between the driver-side FIFOs and the matrix-multiplier interface.

Parameters:
- bits, 32, word width incl. 8-bit ID field in [bits-1:bits-8]
- drvrs, 5, number of drivers (2..8)
- broadcast, {8{1'b1}}, ID value meaning "all drivers except source"
- TIMEOUT, 16, max DELIVER stall cycles (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pndng  in  drvrs  driver i FIFO non-empty; FWFT, so D_pop lane i is valid while pndng[i]=1
- D_pop  in  drvrs*bits  head word of each driver FIFO, lane i = [i*bits +: bits]
- full  in  drvrs  destination FIFO i cannot accept a push
- pop  out  drvrs  one-hot, 1-cycle pop strobe
- push  out  drvrs  1-cycle push strobe; one bit set, or several for broadcast
- D_push  out  drvrs*bits  held word replicated on every lane
- gnt_id  out  3  index of the current/last granted driver
- busy  out  1  FSM not in IDLE
- drop  out  1  1-cycle pulse when a word is discarded

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-high. Already decided.
- Reset values: pop=0, push=0, D_push=0, gnt_id=0, busy=0, drop=0, state=IDLE, last_grant=drvrs-1 (driver 0 wins first), hold register=0.
- IDLE:
  - If pndng==0, stay.
  - Otherwise select the winner: the first i with pndng[i]=1, scanning last_grant+1, last_grant+2, ... modulo drvrs.
  - Register gnt_id=winner, latch D_pop lane winner into the hold register, go to POP.
- POP (1 cycle):
  - pop[gnt_id]=1; last_grant<=gnt_id.
  - Decode id=hold[bits-1:bits-8] to form the target mask:
    - id==broadcast -> all ones except the gnt_id bit.
    - id<drvrs and id!=gnt_id -> one-hot(id).
    - Otherwise (id>=drvrs or id==gnt_id) -> illegal.
  - Legal target -> DELIVER. Illegal target -> drop=1 for 1 cycle, go to IDLE.
- DELIVER:
  - While (mask & full)!=0, wait with push=0. Broadcast is atomic: all targets must be non-full in the same cycle.
  - When the condition clears, push=mask for exactly 1 cycle, D_push=hold on all lanes, go to IDLE.
- Timing: minimum latency is pndng rise -> pop at edge+1 -> push at edge+2. Peak throughput is 1 word per 3 cycles.
- pndng dropping during POP/DELIVER is ignored; the word is already held.
- pndng changes while not in IDLE do not affect the current transaction.
- Reset mid-transaction: the in-flight word is lost. No push is issued after reset deassertion; the FSM restarts in IDLE with driver 0 highest priority.
- A driver with a continuously pending FIFO cannot be granted twice in a row while any other driver is pending.

Optional Feature:
- Macro: PRLL_BS_STALL_TIMEOUT_EN.
- Defined: a stall counter runs in DELIVER. After TIMEOUT consecutive cycles with (mask & full)!=0, the word is discarded: drop=1, push=0, return to IDLE. The counter clears on every DELIVER entry.
- Undefined: DELIVER waits indefinitely; no counter is instantiated.

Decomposition:
- Shared package prll_bs_pkg:
  - state enum {IDLE, POP, DELIVER}
  - ID_W=8, BCAST_ID default
  - function id_of(word) returning the top ID_W bits
- One sub-module: prll_bs_rr_pick, combinational. Inputs: pndng vector and last_grant. Outputs: winner index and valid. Reused for future multi-bus variants.

Test Plan:
- Driver 2 pndng, word 0x01_00ABCD:
  - pop[2] pulses 1 cycle after pndng rises.
  - push=5'b00010 with D_push=0x0100ABCD on the next cycle.
  - busy high for 2 cycles.
- All 5 drivers held pending, each word targeting driver (i+1)%5:
  - Grants issue in order 0,1,2,3,4,0.
  - One push every 3 cycles.
  - No driver is granted twice consecutively.
- Driver 1 word 0xFF_000055:
  - push=5'b11101 in a single cycle.
  - With full[3]=1 for 4 cycles, push stays 0 until full[3] falls, then push=5'b11101 once.
- Driver 0 words with ID 0x07 and ID 0x00 (self): drop pulses 1 cycle after each pop; no push.
- Assert reset while in DELIVER with full held high:
  - All outputs read 0 immediately (asynchronous).
  - After release with only pndng[4]=1, pop[4] pulses; no stale push.
- With PRLL_BS_STALL_TIMEOUT_EN and TIMEOUT=16, hold full[2]=1 for a word targeting driver 2: drop pulses after 16 stall cycles and the FSM returns to IDLE. Without the macro, the FSM stays in DELIVER.
